slave_tx_arbiter: RTL and testbench
===================================

// Module: slave_tx_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single slave->master serial return line among N slave_out_port instances.
//  Each slave raises s_valid when it has a byte. The arbiter grants one slave and forwards m_ready to it only.
//  It muxes that slave's tx_data onto the line and holds the grant until the slave's s_tx_done.
//  A watchdog recovers the bus from a granted slave that never completes.
// PARAMETERS
//  N_SLAVES        4     number of requesting slave ports (2..16)
//  TIMEOUT_CYCLES  64    max unstalled BUSY cycles per grant before forced release (>=16)
// PORTS
//  clk            in   1            system clock, rising edge
//  rstn           in   1            asynchronous active-low reset
//  m_ready        in   1            master ready to receive serial data
//  s_valid        in   N_SLAVES     per-slave request (byte loaded, wants bus)
//  s_tx_done      in   N_SLAVES     per-slave end-of-frame pulse
//  s_tx_data      in   N_SLAVES     per-slave serial bit
//  s_m_ready      out  N_SLAVES     per-slave gated m_ready (one-hot or zero)
//  m_tx_data      out  1            serial line to master
//  bus_busy       out  1            high while a grant is held
//  grant_id       out  clog2(N)     index of granted slave (valid when bus_busy)
//  timeout_err    out  1            one-cycle pulse on watchdog release
// BEHAVIOUR
//  Reset (async assert, sync deassert by top): state=IDLE, rr_ptr=N_SLAVES-1, s_m_ready=0, m_tx_data=1 (idle high),
//   bus_busy=0, grant_id=0, timeout_err=0, wd_cnt=0.
//  FSM arb_state_t {IDLE, BUSY, RELEASE}:
//   IDLE: if |s_valid && m_ready: grant = first set s_valid scanning rr_ptr+1, rr_ptr+2, ... mod N.
//    Registered. Next state BUSY; grant_id updates the same edge.
//    If there is no request or m_ready=0, stay in IDLE.
//   BUSY: s_m_ready[grant]=m_ready, all others 0. m_tx_data = s_tx_data[grant]. bus_busy=1.
//    On s_tx_done[grant]: go to RELEASE and set rr_ptr=grant.
//    If wd_cnt==TIMEOUT_CYCLES-1 and m_ready: go to RELEASE, set rr_ptr=grant, pulse timeout_err.
//   RELEASE: one cycle. s_m_ready=0, m_tx_data=1, bus_busy=0. Always go to IDLE.
//    This gap gives the slave's s_valid time to drop.
//  Latency: request with m_ready high -> s_m_ready[g] high 1 cycle after the sampling edge.
//   Minimum back-to-back grant spacing is s_tx_done edge + 2 cycles.
//  Watchdog: wd_cnt clears on entering BUSY and increments only in BUSY with m_ready=1.
//   Master stall (m_ready=0) freezes it.
//  Simultaneous: s_tx_done and timeout on the same cycle -> treated as normal done; no timeout_err.
//  s_tx_done from a non-granted slave is ignored. s_valid dropping mid-grant is ignored; only done/timeout release.
//  m_ready deassert mid-frame: forwarded low to granted slave; grant held; m_tx_data still follows the slave.
//  rr_ptr wraps N_SLAVES-1 -> 0. A single requester is re-granted after RELEASE; it is not starved.
//  Reset mid-BUSY: all outputs return to reset values immediately (async).
//  All outputs are registered or decoded from state/grant only; no combinational path from s_valid to s_m_ready.
//   Exceptions: the m_ready -> s_m_ready[g] gate and the s_tx_data -> m_tx_data mux are combinational.
// STRUCTURE
//  serial_bus_pkg:
//   arb_state_t enum
//   IDLE_LINE = 1'b1
//   function clog2_min1
//  Sub-module rr_pick #(N): combinational rotate-priority encoder.
//   Inputs: req[N], ptr. Outputs: gnt_idx, any.
//   One instance.
//  Top holds FSM, grant/ptr registers, watchdog counter, output gate/mux (~200 lines total).
// TESTING
//  1. Reset, s_valid=4'b0100, m_ready=1 -> grant_id=2 and s_m_ready=4'b0100 one cycle later.
//     Drive s_tx_done[2] -> RELEASE then IDLE, bus_busy low for 1 cycle.
//  2. s_valid=4'b1111 held, each slave pulses done after 10 cycles -> grant order 0,1,2,3,0 (rr fairness, wrap).
//  3. Granted slave 1 drives s_tx_data=0xCC serially MSB-first -> m_tx_data matches bit-for-bit.
//     Non-granted slaves toggling s_tx_data have no effect.
//  4. Grant slave 3, never send done, m_ready=1 -> timeout_err pulse after exactly 64 BUSY cycles, then re-arbitration.
//     Repeat with m_ready low for 20 cycles mid-grant -> pulse at cycle 84.
//  5. m_ready drops 10 cycles mid-frame -> s_m_ready[g]=0 during stall, grant_id stable, frame completes after resume.
//  6. Assert rstn=0 mid-BUSY -> s_m_ready=0, m_tx_data=1, bus_busy=0 within the same cycle.
//     After release, s_valid=4'b0010 -> grant_id=1.

Source files
------------

// File: rtl/serial_bus_pkg.sv
// Shared types and helpers for the slave->master serial return path.
package serial_bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

   localparam logic IDLE_LINE = 1'b1;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/slave_tx_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request after ptr, wrapping mod N.
module rr_pick
   import serial_bus_pkg::*;
#(
   parameter int N = 4,
   parameter int W = clog2_min1(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [W-1:0] gnt_idx_o,
   output logic         any_o
);

   int unsigned k;
   logic [W-1:0] idx;

   // Scan from farthest to nearest so the nearest request wins.
   always_comb begin
      gnt_idx_o = '0;
      any_o     = |req_i;
      k         = 0;
      idx       = '0;
      for (int i = N; i >= 1; i--) begin
         k   = (int'(ptr_i) + i) % N;
         idx = W'(k);
         if (req_i[idx]) gnt_idx_o = idx;
      end
   end

endmodule

// File: rtl/slave_tx_arbiter.sv
// Round-robin owner of the shared serial return line, with a stall-aware
// watchdog that reclaims the bus from a slave that never signals done.
module slave_tx_arbiter
   import serial_bus_pkg::*;
#(
   parameter int N_SLAVES       = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int GW             = clog2_min1(N_SLAVES)
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                m_ready,
   input  logic [N_SLAVES-1:0] s_valid,
   input  logic [N_SLAVES-1:0] s_tx_done,
   input  logic [N_SLAVES-1:0] s_tx_data,
   output logic [N_SLAVES-1:0] s_m_ready,
   output logic                m_tx_data,
   output logic                bus_busy,
   output logic [GW-1:0]       grant_id,
   output logic                timeout_err
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   arb_state_t      state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            timeout_q, timeout_d;

   logic [GW-1:0]   pick_idx;
   logic            pick_any;
   logic            busy;

   rr_pick #(
      .N (N_SLAVES),
      .W (GW)
   ) u_pick (
      .req_i     (s_valid),
      .ptr_i     (rr_ptr_q),
      .gnt_idx_o (pick_idx),
      .any_o     (pick_any)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         rr_ptr_q  <= GW'(N_SLAVES - 1);
         wd_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         wd_cnt_q  <= wd_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      wd_cnt_d  = wd_cnt_q;
      timeout_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_any && m_ready) begin
               state_d  = BUSY;
               grant_d  = pick_idx;
               wd_cnt_d = '0;
            end
         end
         BUSY: begin
            // A real done outranks a coincident watchdog expiry.
            if (s_tx_done[grant_q]) begin
               state_d  = RELEASE;
               rr_ptr_d = grant_q;
            end else if (m_ready && (wd_cnt_q == WD_LAST)) begin
               state_d   = RELEASE;
               rr_ptr_d  = grant_q;
               timeout_d = 1'b1;
            end else if (m_ready) begin
               wd_cnt_d = wd_cnt_q + 1'b1;
            end
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy        = (state_q == BUSY);
   assign bus_busy    = busy;
   assign grant_id    = grant_q;
   assign timeout_err = timeout_q;
   assign m_tx_data   = busy ? s_tx_data[grant_q] : IDLE_LINE;

   always_comb begin
      s_m_ready = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         s_m_ready[i] = busy && m_ready && (grant_q == GW'(i));
      end
   end

endmodule

// File: tb/tb_slave_tx_arbiter.sv
// Directed bench for slave_tx_arbiter with a grant-order scoreboard.
module tb_slave_tx_arbiter;

   localparam int N = 4;

   logic         clk;
   logic         rstn;
   logic         m_ready;
   logic [N-1:0] s_valid;
   logic [N-1:0] s_tx_done;
   logic [N-1:0] s_tx_data;
   logic [N-1:0] s_m_ready;
   logic         m_tx_data;
   logic         bus_busy;
   logic [1:0]   grant_id;
   logic         timeout_err;

   int n_cmp;
   int n_err;
   int exp_q[$];

   slave_tx_arbiter #(
      .N_SLAVES       (N),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .m_ready     (m_ready),
      .s_valid     (s_valid),
      .s_tx_done   (s_tx_done),
      .s_tx_data   (s_tx_data),
      .s_m_ready   (s_m_ready),
      .m_tx_data   (m_tx_data),
      .bus_busy    (bus_busy),
      .grant_id    (grant_id),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn      = 1'b0;
      m_ready   = 1'b0;
      s_valid   = '0;
      s_tx_done = '0;
      s_tx_data = '1;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // Wait for bus_busy, then compare grant_id with the scoreboard head.
   task automatic wait_grant(input string tag, output int lat);
      int exp;
      lat = 0;
      while (bus_busy !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_seen"}, 32'(lat < 40), 32'd1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk({tag, "_id"}, 32'(grant_id), 32'(exp));
      chk({tag, "_srdy"}, 32'(s_m_ready), 32'(1 << exp));
   endtask

   task automatic pulse_done(input string tag, input int g);
      s_tx_done = 4'(1 << g);
      @(negedge clk);
      s_tx_done = '0;
      chk({tag, "_rel_busy"}, 32'(bus_busy), 32'd0);
      chk({tag, "_rel_srdy"}, 32'(s_m_ready), 32'd0);
      chk({tag, "_rel_line"}, 32'(m_tx_data), 32'd1);
   endtask

   task automatic run_timeout(input string tag, input bit stall);
      int cnt;
      cnt = 0;
      while (bus_busy === 1'b1 && cnt < 300) begin
         cnt++;
         if (stall && cnt == 10) m_ready = 1'b0;
         if (stall && cnt == 30) m_ready = 1'b1;
         chk({tag, "_no_early"}, 32'(timeout_err), 32'd0);
         @(negedge clk);
      end
      chk({tag, "_cycles"}, 32'(cnt), stall ? 32'd84 : 32'd64);
      chk({tag, "_pulse"}, 32'(timeout_err), 32'd1);
      @(negedge clk);
      chk({tag, "_pulse_end"}, 32'(timeout_err), 32'd0);
   endtask

   initial begin
      int lat;
      int ptr;
      int g;
      logic [7:0] byte_v;
      n_cmp = 0;
      n_err = 0;
      rstn = 1'b1;
      m_ready = 1'b0;
      s_valid = '0;
      s_tx_done = '0;
      s_tx_data = '1;

      // 1: reset values, single request latency, release gap
      do_reset();
      chk("rst_srdy", 32'(s_m_ready), 32'd0);
      chk("rst_line", 32'(m_tx_data), 32'd1);
      chk("rst_busy", 32'(bus_busy), 32'd0);
      chk("rst_gid", 32'(grant_id), 32'd0);
      chk("rst_to", 32'(timeout_err), 32'd0);
      s_valid = 4'b0100;
      m_ready = 1'b1;
      exp_q.push_back(2);
      wait_grant("t1", lat);
      chk("t1_lat", 32'(lat), 32'd1);
      s_valid = '0;
      pulse_done("t1", 2);
      @(negedge clk);
      chk("t1_idle_busy", 32'(bus_busy), 32'd0);

      // 2: all requesting, fairness with wrap
      do_reset();
      s_valid = 4'b1111;
      m_ready = 1'b1;
      ptr = N - 1;
      for (int r = 0; r < 5; r++) begin
         g = (ptr + 1) % N;
         ptr = g;
         exp_q.push_back(g);
         wait_grant($sformatf("t2_%0d", r), lat);
         repeat (10) @(negedge clk);
         chk($sformatf("t2_%0d_hold", r), 32'(grant_id), 32'(g));
         pulse_done($sformatf("t2_%0d", r), g);
      end
      s_valid = '0;

      // 3: serial byte passes through, others ignored
      do_reset();
      s_valid = 4'b0010;
      m_ready = 1'b1;
      exp_q.push_back(1);
      wait_grant("t3", lat);
      byte_v = 8'hCC;
      for (int b = 7; b >= 0; b--) begin
         s_tx_data = 4'($urandom_range(0, 15));
         s_tx_data[1] = byte_v[b];
         #1;
         chk($sformatf("t3_bit%0d", b), 32'(m_tx_data), 32'(byte_v[b]));
         @(negedge clk);
      end
      s_tx_done = 4'b0100;
      @(negedge clk);
      s_tx_done = '0;
      chk("t3_foreign_done", 32'(bus_busy), 32'd1);
      s_valid = '0;
      pulse_done("t3", 1);

      // 4: watchdog, free-running then with a 20-cycle stall
      do_reset();
      s_valid = 4'b1000;
      m_ready = 1'b1;
      exp_q.push_back(3);
      wait_grant("t4a", lat);
      run_timeout("t4a", 1'b0);
      exp_q.push_back(3);
      wait_grant("t4b", lat);
      run_timeout("t4b", 1'b1);
      s_valid = '0;
      repeat (3) @(negedge clk);

      // 5: master stall mid-frame
      s_valid = 4'b0001;
      exp_q.push_back(0);
      wait_grant("t5", lat);
      repeat (3) @(negedge clk);
      m_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         s_tx_data[0] = c[0];
         #1;
         chk("t5_stall_srdy", 32'(s_m_ready), 32'd0);
         chk("t5_stall_gid", 32'(grant_id), 32'd0);
         chk("t5_stall_line", 32'(m_tx_data), 32'(c[0]));
         @(negedge clk);
      end
      m_ready = 1'b1;
      #1;
      chk("t5_resume_srdy", 32'(s_m_ready), 32'd1);
      chk("t5_resume_busy", 32'(bus_busy), 32'd1);
      s_valid = '0;
      pulse_done("t5", 0);

      // 6: async reset during a grant
      @(negedge clk);
      s_valid = 4'b0100;
      exp_q.push_back(2);
      wait_grant("t6", lat);
      s_tx_data = '0;
      #2;
      rstn = 1'b0;
      #1;
      chk("t6_rst_srdy", 32'(s_m_ready), 32'd0);
      chk("t6_rst_line", 32'(m_tx_data), 32'd1);
      chk("t6_rst_busy", 32'(bus_busy), 32'd0);
      @(negedge clk);
      s_valid = 4'b0010;
      rstn = 1'b1;
      exp_q.push_back(1);
      wait_grant("t6_after", lat);
      chk("t6_lat", 32'(lat), 32'd1);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
